// File: rtl/wbc_vic_pkg.sv
// Shared types and constants for the wbc_vic vectored interrupt controller.
// Holds the FSM encoding, the default spurious vector and the channel-count limit.
package vic_pkg;

  typedef enum logic [1:0] {
    VIC_IDLE = 2'd0,
    VIC_ACK  = 2'd1,
    VIC_HOLD = 2'd2
  } vic_state_e;

  localparam logic [15:0] VIC_SPUR_VEC = 16'o000000;
  localparam int          VIC_MAX_N    = 8;
  localparam int          VIC_PTR_W    = $clog2(VIC_MAX_N);

  // Index of the set bit in a one-hot word; zero when nothing is set.
  function automatic logic [VIC_PTR_W-1:0] vic_onehot_idx(input logic [VIC_MAX_N-1:0] oh);
    logic [VIC_PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < VIC_MAX_N; i++) begin
      if (oh[i]) idx = VIC_PTR_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/wbc_vic_if.sv
// CPU-side vector-fetch port of wbc_vic: virq / istb / ivec / iack.
// The controller uses the slave modport, the CPU (or bench) the master modport.
interface wbc_vic_if;
  logic        virq_o;
  logic        wbi_stb_i;
  logic [15:0] wbi_dat_o;
  logic        wbi_ack_o;

  modport slave (
    input  wbi_stb_i,
    output virq_o,
    output wbi_dat_o,
    output wbi_ack_o
  );

  modport master (
    output wbi_stb_i,
    input  virq_o,
    input  wbi_dat_o,
    input  wbi_ack_o
  );
endinterface

// File: rtl/wbc_vic_prio_enc.sv
// Combinational priority encoder: the requesting channel closest to base_i
// (counting upward and wrapping at N-1) wins; none_o flags an empty request word.
module vic_prio_enc
  import vic_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [VIC_PTR_W-1:0] base_i,
  output logic [N-1:0]         gnt_o,
  output logic                 none_o
);

  int b;
  int d;
  int best;
  int pick;

  always_comb begin
    b      = int'(base_i);
    d      = 0;
    best   = N;
    pick   = 0;
    gnt_o  = '0;
    none_o = 1'b1;
    // Distance from the base decides priority; the smallest distance wins.
    for (int j = 0; j < N; j++) begin
      d = (j >= b) ? (j - b) : (j + N - b);
      if (req_i[j] && (d < best)) begin
        best   = d;
        pick   = j;
        none_o = 1'b0;
      end
    end
    for (int j = 0; j < N; j++) begin
      gnt_o[j] = !none_o && (j == pick);
    end
  end

endmodule

// File: rtl/wbc_vic.sv
// Vectored interrupt controller answering the CPU interrupt-acknowledge handshake.
// Define VIC_ROTATE_EN for round-robin priority; default is fixed, channel 0 highest.
module wbc_vic
  import vic_pkg::*;
#(
  parameter int          N        = 4,
  parameter logic [15:0] SPUR_VEC = VIC_SPUR_VEC
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [N-1:0]    dev_irq,
  input  logic [16*N-1:0] dev_vec,
  output logic [N-1:0]    dev_ack,
  wbc_vic_if.slave        cpu
);

  vic_state_e           state_q;
  logic                 virq_q;
  logic                 ack_q;
  logic [15:0]          dat_q;
  logic [N-1:0]         dev_ack_q;

  logic [N-1:0]         gnt;
  logic                 none;
  logic [15:0]          vec_d;
  logic [VIC_PTR_W-1:0] base;

`ifdef VIC_ROTATE_EN
  logic [VIC_PTR_W-1:0] ptr_q;
  logic [VIC_PTR_W-1:0] ptr_d;
  logic [VIC_MAX_N-1:0] gnt_ext;
  int                   nxt;

  // Next search starts one past the channel being granted now.
  always_comb begin
    gnt_ext        = '0;
    gnt_ext[N-1:0] = gnt;
    nxt            = int'(vic_onehot_idx(gnt_ext)) + 1;
    if (nxt >= N) nxt = 0;
    ptr_d          = VIC_PTR_W'(nxt);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ptr_q <= '0;
    end else if ((state_q == VIC_IDLE) && cpu.wbi_stb_i && !none) begin
      ptr_q <= ptr_d;
    end
  end

  assign base = ptr_q;
`else
  assign base = '0;
`endif

  vic_prio_enc #(.N(N)) u_prio (
    .req_i  (dev_irq),
    .base_i (base),
    .gnt_o  (gnt),
    .none_o (none)
  );

  always_comb begin
    vec_d = SPUR_VEC;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) vec_d = dev_vec[16*i +: 16];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= VIC_IDLE;
      virq_q    <= 1'b0;
      ack_q     <= 1'b0;
      dat_q     <= '0;
      dev_ack_q <= '0;
    end else begin
      dev_ack_q <= '0;
      unique case (state_q)
        VIC_IDLE: begin
          if (cpu.wbi_stb_i) begin
            state_q   <= VIC_ACK;
            ack_q     <= 1'b1;
            virq_q    <= 1'b0;
            dat_q     <= vec_d;
            dev_ack_q <= none ? '0 : gnt;
          end else begin
            virq_q <= |dev_irq;
          end
        end
        VIC_ACK: begin
          if (!cpu.wbi_stb_i) begin
            state_q <= VIC_HOLD;
            ack_q   <= 1'b0;
          end
        end
        // Served device has had a cycle to drop its level before we resample.
        VIC_HOLD: begin
          state_q <= VIC_IDLE;
          virq_q  <= |dev_irq;
        end
        default: begin
          state_q <= VIC_IDLE;
          ack_q   <= 1'b0;
          virq_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dev_ack       = dev_ack_q;
  assign cpu.virq_o    = virq_q;
  assign cpu.wbi_ack_o = ack_q;
  assign cpu.wbi_dat_o = dat_q;

endmodule

// File: tb/tb_wbc_vic.sv
// Self-checking bench for wbc_vic: directed handshake cases plus random requests
// compared against a scan-from-start priority model.
module tb_wbc_vic;

  localparam logic [15:0] SPUR = 16'o000174;
`ifdef VIC_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  irq;
  logic [63:0] vec;
  logic [3:0]  dack;
  logic [3:0]  got;
  int          errors = 0;
  int          checks = 0;
  int          mptr   = 0;

  wbc_vic_if bus ();

  wbc_vic #(.N(4), .SPUR_VEC(SPUR)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .dev_irq  (irq),
    .dev_vec  (vec),
    .dev_ack  (dack),
    .cpu      (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] ref_grant(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (start + k) % 4;
      if (r[idx]) return 4'b0001 << idx;
    end
    return 4'b0000;
  endfunction

  // One full vector fetch: strobe for len cycles, optional device drop on dev_ack.
  task automatic fetch(input int len, input bit drop, input string tag, output logic [3:0] gnt_seen);
    logic [3:0]  g;
    logic [15:0] ev;
    logic [63:0] vsave;
    int          gi;
    g  = ref_grant(irq, ROT ? mptr : 0);
    ev = SPUR;
    gi = -1;
    for (int i = 0; i < 4; i++) begin
      if (g[i]) begin
        ev = vec[16*i +: 16];
        gi = i;
      end
    end
    bus.wbi_stb_i = 1'b1;
    step;
    gnt_seen = dack;
    chk({tag, "_ack1"}, 32'(bus.wbi_ack_o), 32'd1);
    chk({tag, "_dat1"}, 32'(bus.wbi_dat_o), 32'(ev));
    chk({tag, "_devack1"}, 32'(dack), 32'(g));
    chk({tag, "_virq1"}, 32'(bus.virq_o), 32'd0);
    if (gi >= 0) mptr = (gi + 1) % 4;
    if (drop) irq = irq & ~g;
    vsave = vec;
    vec   = {$urandom, $urandom};
    for (int k = 1; k < len; k++) begin
      step;
      chk({tag, "_ackN"}, 32'(bus.wbi_ack_o), 32'd1);
      chk({tag, "_datN"}, 32'(bus.wbi_dat_o), 32'(ev));
      chk({tag, "_devackN"}, 32'(dack), 32'd0);
      chk({tag, "_virqN"}, 32'(bus.virq_o), 32'd0);
    end
    vec = vsave;
    bus.wbi_stb_i = 1'b0;
    step;
    chk({tag, "_hold_ack"}, 32'(bus.wbi_ack_o), 32'd0);
    chk({tag, "_hold_virq"}, 32'(bus.virq_o), 32'd0);
    chk({tag, "_hold_devack"}, 32'(dack), 32'd0);
    step;
    chk({tag, "_idle_virq"}, 32'(bus.virq_o), 32'(|irq));
    chk({tag, "_idle_ack"}, 32'(bus.wbi_ack_o), 32'd0);
  endtask

  initial begin
    rst           = 1'b1;
    irq           = 4'b1111;
    vec           = '0;
    bus.wbi_stb_i = 1'b0;
    step;
    step;
    chk("rst_virq", 32'(bus.virq_o), 32'd0);
    chk("rst_ack", 32'(bus.wbi_ack_o), 32'd0);
    chk("rst_dat", 32'(bus.wbi_dat_o), 32'd0);
    chk("rst_devack", 32'(dack), 32'd0);
    rst  = 1'b0;
    mptr = 0;
    step;
    chk("rel_virq", 32'(bus.virq_o), 32'd1);

    irq = 4'b0100;
    vec[47:32] = 16'o000060;
    step;
    fetch(1, 1'b1, "single", got);
    chk("single_grant", 32'(got), 32'b0100);

    irq = 4'b1010;
    vec[31:16] = 16'o000064;
    vec[63:48] = 16'o000100;
    step;
    fetch(1, 1'b1, "prio_a", got);
    fetch(1, 1'b1, "prio_b", got);

    irq = 4'b0000;
    step;
    chk("spur_virq", 32'(bus.virq_o), 32'd0);
    fetch(2, 1'b0, "spur", got);
    chk("spur_grant", 32'(got), 32'd0);

    irq = 4'b0011;
    vec[15:0] = 16'o000070;
    step;
    fetch(5, 1'b1, "hs5", got);

    irq = 4'b0100;
    step;
    bus.wbi_stb_i = 1'b1;
    step;
    chk("midrst_pre_ack", 32'(bus.wbi_ack_o), 32'd1);
    rst = 1'b1;
    step;
    chk("midrst_ack", 32'(bus.wbi_ack_o), 32'd0);
    chk("midrst_dat", 32'(bus.wbi_dat_o), 32'd0);
    chk("midrst_devack", 32'(dack), 32'd0);
    chk("midrst_virq", 32'(bus.virq_o), 32'd0);
    mptr = 0;
    rst = 1'b0;
    bus.wbi_stb_i = 1'b0;
    step;
    chk("midrst_virq_back", 32'(bus.virq_o), 32'd1);

    irq = 4'b1111;
    step;
    for (int i = 0; i < 5; i++) begin
      fetch(1, 1'b0, "order", got);
      chk("order_grant", 32'(got), ROT ? 32'(4'b0001 << (i % 4)) : 32'd1);
    end
    bus.wbi_stb_i = 1'b1;
    step;
    rst = 1'b1;
    step;
    chk("rr_rst_devack", 32'(dack), 32'd0);
    mptr = 0;
    rst = 1'b0;
    bus.wbi_stb_i = 1'b0;
    step;
    fetch(1, 1'b0, "after_rst", got);
    chk("after_rst_grant", 32'(got), 32'd1);

    for (int n = 0; n < 24; n++) begin
      irq = 4'($urandom);
      vec = {$urandom, $urandom};
      step;
      chk("rnd_virq", 32'(bus.virq_o), 32'(|irq));
      for (int w = 0; w < int'($urandom_range(0, 2)); w++) begin
        step;
        chk("rnd_idle_virq", 32'(bus.virq_o), 32'(|irq));
      end
      fetch(int'($urandom_range(1, 4)), 1'($urandom), "rnd", got);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
